// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, coordinate type and helpers
//
// Purpose: default 640x480@60 Hz timing, coordinate width/type, run-state
// enum and a window-compare helper used by the raster decodes.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Half-open window test lo <= c < hi, done in int so bounds of 1024 cannot wrap.
  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and drawing stage
//
// Purpose: groups the raster outputs of vga_timing_gen.
// Signals:
//   DrawX, DrawY   current pixel column / line
//   blank          1 = visible pixel
//   hs, vs         sync pulses, active low
//   frame_start    one-cycle pulse at (0,0)
//   vblank_start   one-cycle pulse at (0,V_VISIBLE)
//   frame_count    completed-frame counter
// Modports: master (generator drives), slave (consumer reads).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, vblank_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, frame pulses)
//
// Purpose: free-running horizontal/vertical counters with registered decodes
// that line up with DrawX/DrawY in the same cycle.
// Ports:
//   vga_clk  in   pixel clock, all state on rising edge
//   reset    in   asynchronous active-high reset
//   vga      master modport of vga_timing_gen_if (all raster outputs)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  run_state_t  state_q, state_d;
  coord_t      hc_q, vc_q;
  coord_t      hc_d, vc_d;
  logic        frame_wrap;
  logic        hs_q, vs_q, blank_q, fs_q, vbs_q;
  logic        hs_d, vs_d, blank_d, fs_d, vbs_d;
  logic [15:0] frame_count_q;

  // Running flag: one idle edge after reset, then run forever.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end
  end

  // Next coordinate. In IDLE the counters hold at (0,0) so the first edge
  // after release loads the (0,0) decode.
  always_comb begin
    hc_d       = hc_q;
    vc_d       = vc_q;
    frame_wrap = 1'b0;
    if (state_q == ST_RUN) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d       = '0;
          frame_wrap = 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Decodes are taken from the coordinate being loaded so they register
  // alongside it and describe the same pixel.
  always_comb begin
    hs_d    = ~in_window(hc_d, HS_START, HS_END);
    vs_d    = ~in_window(vc_d, VS_START, VS_END);
    blank_d = (int'(hc_d) < H_VISIBLE) && (int'(vc_d) < V_VISIBLE);
    fs_d    = (hc_d == '0) && (vc_d == '0);
    vbs_d   = (hc_d == '0) && (int'(vc_d) == V_VISIBLE);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      vbs_q   <= vbs_d;
    end
  end

  // Counts completed frames; bumps on the same edge that loads (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_wrap) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign vga.DrawX        = hc_q;
  assign vga.DrawY        = vc_q;
  assign vga.blank        = blank_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vbs_q;
  assign vga.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and reduced timing)
module tb_vga_timing_gen;

  typedef struct {
    int    n;
    int    x;
    int    y;
    int    blank;
    int    hs;
    int    vs;
    int    fs;
    int    vbs;
    int    fc;
    string name;
  } exp_t;

  logic vga_clk;
  logic rst_full;
  logic rst_small;

  int checks   = 0;
  int failures = 0;

  int n_full;
  int n_small;

  exp_t q_full[$];
  exp_t q_small[$];

  event ev_full;

  vga_timing_gen_if full_if ();
  vga_timing_gen_if small_if ();

  vga_timing_gen u_full (
    .vga_clk (vga_clk),
    .reset   (rst_full),
    .vga     (full_if)
  );

  vga_timing_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (5),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) u_small (
    .vga_clk (vga_clk),
    .reset   (rst_small),
    .vga     (small_if)
  );

  initial begin
    vga_clk = 1'b0;
    forever #20 vga_clk = ~vga_clk;
  end

  // Edge index since reset release: edge k shows linear pixel k-1.
  always @(posedge vga_clk or posedge rst_full) begin
    if (rst_full) n_full <= 0;
    else          n_full <= n_full + 1;
  end

  always @(posedge vga_clk or posedge rst_small) begin
    if (rst_small) n_small <= 0;
    else           n_small <= n_small + 1;
  end

  function automatic exp_t mk(int n, int x, int y, int b, int hs, int vs,
                              int fs, int vbs, int fc, string nm);
    exp_t e;
    e.n = n; e.x = x; e.y = y; e.blank = b; e.hs = hs; e.vs = vs;
    e.fs = fs; e.vbs = vbs; e.fc = fc; e.name = nm;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp_rec(exp_t e, int x, int y, int b, int hs, int vs,
                         int fs, int vbs, int fc);
    chk({e.name, ".DrawX"}, x, e.x);
    chk({e.name, ".DrawY"}, y, e.y);
    chk({e.name, ".blank"}, b, e.blank);
    chk({e.name, ".hs"}, hs, e.hs);
    chk({e.name, ".vs"}, vs, e.vs);
    chk({e.name, ".frame_start"}, fs, e.fs);
    chk({e.name, ".vblank_start"}, vbs, e.vbs);
    chk({e.name, ".frame_count"}, fc, e.fc);
  endtask

  // Monitors: pop every expectation whose edge index has been reached.
  initial begin
    exp_t e;
    forever begin
      @(negedge vga_clk or ev_full);
      while (q_full.size() > 0 && q_full[0].n <= n_full) begin
        e = q_full.pop_front();
        if (e.n < n_full) begin
          chk({e.name, ".missed_at_edge"}, n_full, e.n);
        end else begin
          cmp_rec(e, int'(full_if.DrawX), int'(full_if.DrawY), int'(full_if.blank),
                  int'(full_if.hs), int'(full_if.vs), int'(full_if.frame_start),
                  int'(full_if.vblank_start), int'(full_if.frame_count));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge vga_clk);
      while (q_small.size() > 0 && q_small[0].n <= n_small) begin
        e = q_small.pop_front();
        if (e.n < n_small) begin
          chk({e.name, ".missed_at_edge"}, n_small, e.n);
        end else begin
          cmp_rec(e, int'(small_if.DrawX), int'(small_if.DrawY), int'(small_if.blank),
                  int'(small_if.hs), int'(small_if.vs), int'(small_if.frame_start),
                  int'(small_if.vblank_start), int'(small_if.frame_count));
        end
      end
    end
  end

  // Reduced-timing frame statistics: 16x12 raster gives 192 clocks and 40 visible per frame.
  initial begin
    int period = 0;
    int blanks = 0;
    int have   = 0;
    forever begin
      @(negedge vga_clk);
      if (rst_small) begin
        have = 0;
      end else if (small_if.frame_start) begin
        if (have != 0) begin
          chk("small.frame_period", period, 192);
          chk("small.blank_per_frame", blanks, 40);
        end
        have   = 1;
        period = 1;
        blanks = small_if.blank ? 1 : 0;
      end else begin
        period++;
        if (small_if.blank) blanks++;
      end
    end
  end

  task automatic wait_full(int limit);
    int cnt = 0;
    while (q_full.size() > 0 && cnt < limit) begin
      @(negedge vga_clk);
      #2;
      cnt++;
    end
    if (q_full.size() > 0) begin
      chk("full.drain_timeout", q_full.size(), 0);
      q_full.delete();
    end
  endtask

  task automatic wait_small(int limit);
    int cnt = 0;
    while (q_small.size() > 0 && cnt < limit) begin
      @(negedge vga_clk);
      #2;
      cnt++;
    end
    if (q_small.size() > 0) begin
      chk("small.drain_timeout", q_small.size(), 0);
      q_small.delete();
    end
  endtask

  task automatic full_seq();
    q_full.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, "full.reset"));
    repeat (3) @(negedge vga_clk);
    #5 rst_full = 1'b0;
    q_full.push_back(mk(1,    0,   0, 1, 1, 1, 1, 0, 0, "full.first"));
    q_full.push_back(mk(2,    1,   0, 1, 1, 1, 0, 0, 0, "full.x1"));
    q_full.push_back(mk(640,  639, 0, 1, 1, 1, 0, 0, 0, "full.x639"));
    q_full.push_back(mk(641,  640, 0, 0, 1, 1, 0, 0, 0, "full.x640"));
    q_full.push_back(mk(656,  655, 0, 0, 1, 1, 0, 0, 0, "full.x655"));
    q_full.push_back(mk(657,  656, 0, 0, 0, 1, 0, 0, 0, "full.x656"));
    q_full.push_back(mk(752,  751, 0, 0, 0, 1, 0, 0, 0, "full.x751"));
    q_full.push_back(mk(753,  752, 0, 0, 1, 1, 0, 0, 0, "full.x752"));
    q_full.push_back(mk(800,  799, 0, 0, 1, 1, 0, 0, 0, "full.x799"));
    q_full.push_back(mk(801,  0,   1, 1, 1, 1, 0, 0, 0, "full.line1"));
    q_full.push_back(mk(1101, 300, 1, 1, 1, 1, 0, 0, 0, "full.x300y1"));
    wait_full(1300);
    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    #3 rst_full = 1'b1;
    q_full.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, "full.async_reset"));
    #5 -> ev_full;
    repeat (2) @(negedge vga_clk);
    #5 rst_full = 1'b0;
    q_full.push_back(mk(1,   0, 0, 1, 1, 1, 1, 0, 0, "full.restart"));
    q_full.push_back(mk(2,   1, 0, 1, 1, 1, 0, 0, 0, "full.restart_x1"));
    q_full.push_back(mk(801, 0, 1, 1, 1, 1, 0, 0, 0, "full.restart_line1"));
    wait_full(900);
  endtask

  task automatic small_seq();
    q_small.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, "small.reset"));
    repeat (3) @(negedge vga_clk);
    #5 rst_small = 1'b0;
    q_small.push_back(mk(1,   0,  0,  1, 1, 1, 1, 0, 0, "small.first"));
    q_small.push_back(mk(65,  0,  4,  1, 1, 1, 0, 0, 0, "small.y4"));
    q_small.push_back(mk(72,  7,  4,  1, 1, 1, 0, 0, 0, "small.x7y4"));
    q_small.push_back(mk(73,  8,  4,  0, 1, 1, 0, 0, 0, "small.x8y4"));
    q_small.push_back(mk(75,  10, 4,  0, 0, 1, 0, 0, 0, "small.x10y4"));
    q_small.push_back(mk(81,  0,  5,  0, 1, 1, 0, 1, 0, "small.vblank"));
    q_small.push_back(mk(82,  1,  5,  0, 1, 1, 0, 0, 0, "small.vblank_end"));
    q_small.push_back(mk(112, 15, 6,  0, 1, 1, 0, 0, 0, "small.x15y6"));
    q_small.push_back(mk(113, 0,  7,  0, 1, 0, 0, 0, 0, "small.y7"));
    q_small.push_back(mk(123, 10, 7,  0, 0, 0, 0, 0, 0, "small.x10y7"));
    q_small.push_back(mk(144, 15, 8,  0, 1, 0, 0, 0, 0, "small.x15y8"));
    q_small.push_back(mk(145, 0,  9,  0, 1, 1, 0, 0, 0, "small.y9"));
    q_small.push_back(mk(192, 15, 11, 0, 1, 1, 0, 0, 0, "small.last"));
    q_small.push_back(mk(193, 0,  0,  1, 1, 1, 1, 0, 1, "small.wrap1"));
    q_small.push_back(mk(385, 0,  0,  1, 1, 1, 1, 0, 2, "small.wrap2"));
    wait_small(500);
    force u_small.frame_count_q = 16'hFFFF;
    @(negedge vga_clk);
    #2 release u_small.frame_count_q;
    q_small.push_back(mk(500, 3,  7,  0, 1, 0, 0, 0, 65535, "small.preload_mid"));
    q_small.push_back(mk(576, 15, 11, 0, 1, 1, 0, 0, 65535, "small.preload_last"));
    q_small.push_back(mk(577, 0,  0,  1, 1, 1, 1, 0, 0, "small.fc_wrap"));
    q_small.push_back(mk(578, 1,  0,  1, 1, 1, 0, 0, 0, "small.fc_wrap_x1"));
    wait_small(300);
  endtask

  initial begin
    rst_full  = 1'b1;
    rst_small = 1'b1;
    fork
      full_seq();
      small_seq();
    join
    repeat (2) @(negedge vga_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
